// File: rtl/memwb_stage_if.sv
// Handshake bundles around the memory/write-back stage.
// memwb_bundle_if: execute -> stage result bundle. The bundle transfers on a
//   clock edge where in_valid and in_ready are both high; while in_ready is
//   low the producer holds in_valid and every bundle field unchanged.
// dmem_if: stage -> data memory request. dmem_req and the request fields stay
//   stable until dmem_ready is sampled high, which completes the request;
//   dmem_rdata is meaningful only alongside dmem_ready.

interface memwb_bundle_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic [31:0] cpsr_passthrough;
   logic        taken;
   logic [31:0] pc_rel;
   logic [3:0]  rd_num_passthrough;
   logic [31:0] rd_val_passthrough;
   logic [31:0] mem_passthrough;
   logic        is_alu_op_passthrough;
   logic        is_cmp_op_passthrough;
   logic        is_ld_op_passthrough;
   logic        is_str_op_passthrough;

   modport master (
      output in_valid, result, cpsr_passthrough, taken, pc_rel,
             rd_num_passthrough, rd_val_passthrough, mem_passthrough,
             is_alu_op_passthrough, is_cmp_op_passthrough,
             is_ld_op_passthrough, is_str_op_passthrough,
      input  in_ready
   );

   modport slave (
      input  in_valid, result, cpsr_passthrough, taken, pc_rel,
             rd_num_passthrough, rd_val_passthrough, mem_passthrough,
             is_alu_op_passthrough, is_cmp_op_passthrough,
             is_ld_op_passthrough, is_str_op_passthrough,
      output in_ready
   );
endinterface

interface dmem_if #(parameter int ADDR_WIDTH = 22);
   logic                  dmem_req;
   logic                  dmem_we;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [31:0]           dmem_wdata;
   logic                  dmem_ready;
   logic [31:0]           dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/memwb_stage.sv
// Memory/write-back stage: latches one execute bundle per handshake, runs
// LD/STR through the data-memory port, then spends exactly one WB cycle
// pulsing the register-file, CPSR and branch-redirect strobes.
// Outputs are decoded from the state register, so they are zero outside
// their own state and fall to zero the moment reset asserts.

module memwb_stage #(
   parameter int ADDR_WIDTH = 22
) (
   input  logic                 clk,
   input  logic                 reset,
   memwb_bundle_if.slave        ex,
   dmem_if.master               dmem,
   output logic [3:0]           wb_rd_num,
   output logic                 wb_rd_write_en,
   output logic [31:0]          wb_rd_in,
   output logic                 wb_cpsr_write_en,
   output logic [31:0]          wb_cpsr_in,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc_rel,
   output logic [31:0]          retired_count,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Latched bundle
   logic [31:0]           result_q;
   logic [31:0]           cpsr_q;
   logic                  taken_q;
   logic [31:0]           pc_rel_q;
   logic [3:0]            rd_num_q;
   logic [31:0]           rd_val_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  alu_q, cmp_q, ld_q, str_q;
   logic [31:0]           rdata_q;
   logic [31:0]           retired_q;

   logic accept;
   logic in_mem, in_wb;

   // Address bits above ADDR_WIDTH are deliberately dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^ex.mem_passthrough[31:ADDR_WIDTH];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake: WB accepts the next bundle in the same cycle
   // so back-to-back non-memory instructions retire one per cycle.
   always_comb begin
      state_d     = state_q;
      ex.in_ready = (state_q != MEM);
      accept      = ex.in_valid && (state_q != MEM);
      case (state_q)
         IDLE, WB: begin
            if (accept) begin
               if (ex.is_ld_op_passthrough || ex.is_str_op_passthrough) begin
                  state_d = MEM;
               end else begin
                  state_d = WB;
               end
            end else begin
               state_d = IDLE;
            end
         end
         MEM: begin
            if (dmem.dmem_ready) begin
               state_d = WB;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bundle capture on accept; load data capture when memory completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         cpsr_q   <= '0;
         taken_q  <= 1'b0;
         pc_rel_q <= '0;
         rd_num_q <= '0;
         rd_val_q <= '0;
         addr_q   <= '0;
         alu_q    <= 1'b0;
         cmp_q    <= 1'b0;
         ld_q     <= 1'b0;
         str_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            result_q <= ex.result;
            cpsr_q   <= ex.cpsr_passthrough;
            taken_q  <= ex.taken;
            pc_rel_q <= ex.pc_rel;
            rd_num_q <= ex.rd_num_passthrough;
            rd_val_q <= ex.rd_val_passthrough;
            addr_q   <= ex.mem_passthrough[ADDR_WIDTH-1:0];
            alu_q    <= ex.is_alu_op_passthrough;
            cmp_q    <= ex.is_cmp_op_passthrough;
            ld_q     <= ex.is_ld_op_passthrough;
            str_q    <= ex.is_str_op_passthrough;
         end
         if (state_q == MEM && dmem.dmem_ready && ld_q) begin
            rdata_q <= dmem.dmem_rdata;
         end
      end
   end

   // Retirement counter: one per WB cycle, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
      end else if (state_q == WB) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   // Output decode from state and latched bundle.
   always_comb begin
      in_mem           = (state_q == MEM);
      in_wb            = (state_q == WB);
      dmem.dmem_req    = in_mem;
      dmem.dmem_we     = in_mem && str_q;
      dmem.dmem_addr   = in_mem ? addr_q : '0;
      dmem.dmem_wdata  = in_mem ? rd_val_q : '0;
      // A bundle flagged both ALU and LD writes the loaded value.
      wb_rd_write_en   = in_wb && (alu_q || ld_q);
      wb_rd_num        = in_wb ? rd_num_q : '0;
      wb_rd_in         = in_wb ? (ld_q ? rdata_q : result_q) : '0;
      wb_cpsr_write_en = in_wb && cmp_q;
      wb_cpsr_in       = in_wb ? cpsr_q : '0;
      redirect_valid   = in_wb && taken_q;
      redirect_pc_rel  = in_wb ? pc_rel_q : '0;
      retired_count    = retired_q;
      state_dbg        = state_q;
   end

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: table of bundles with expected write-back effects,
// a memory responder with per-bundle latency, a WB monitor popping an
// expected queue, and hand-written reset-abort and counter-wrap sequences.

module tb_memwb_stage;
   localparam int W = 103;

   logic clk;
   logic reset;
   logic [3:0]  wb_rd_num;
   logic        wb_rd_write_en;
   logic [31:0] wb_rd_in;
   logic        wb_cpsr_write_en;
   logic [31:0] wb_cpsr_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc_rel;
   logic [31:0] retired_count;
   logic [1:0]  state_dbg;

   memwb_bundle_if bus ();
   dmem_if #(.ADDR_WIDTH(22)) mem ();

   memwb_stage #(.ADDR_WIDTH(22)) dut (
      .clk              (clk),
      .reset            (reset),
      .ex               (bus),
      .dmem             (mem),
      .wb_rd_num        (wb_rd_num),
      .wb_rd_write_en   (wb_rd_write_en),
      .wb_rd_in         (wb_rd_in),
      .wb_cpsr_write_en (wb_cpsr_write_en),
      .wb_cpsr_in       (wb_cpsr_in),
      .redirect_valid   (redirect_valid),
      .redirect_pc_rel  (redirect_pc_rel),
      .retired_count    (retired_count),
      .state_dbg        (state_dbg)
   );

   typedef struct {
      logic        alu, cmp, ld, str, taken;
      logic [31:0] result, cpsr, pc_rel, rd_val, mem;
      logic [3:0]  rd;
      int          lat;
      logic [31:0] rdata;
      logic        e_rd_we;
      logic [3:0]  e_rd_num;
      logic [31:0] e_rd_in;
      logic        e_cpsr_we;
      logic [31:0] e_cpsr;
      logic        e_redir;
      logic [31:0] e_pc;
      logic [21:0] e_addr;
   } vec_t;

   logic [W-1:0] exp_q[$];
   logic [31:0]  exp_ret;
   int checks;
   int errors;

   // Memory responder expectations (set by driver, latched at request start)
   int          mem_lat;
   logic [31:0] mem_rdata;
   logic [21:0] mem_exp_addr;
   logic        mem_exp_we;
   logic [31:0] mem_exp_wdata;
   logic        mem_exp_valid;
   logic        abort_exp;
   int          mem_cycles;
   int          cur_lat;
   logic [31:0] cur_rdata;
   logic [21:0] cur_addr;
   logic        cur_we;
   logic [31:0] cur_wdata;

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory responder: ready after cur_lat request cycles, random ready when idle.
   always @(negedge clk) begin
      if (mem.dmem_req) begin
         if (mem_cycles == 0) begin
            chk("dmem_req_expected", 1'b1, mem_exp_valid);
            cur_lat   = mem_lat;
            cur_rdata = mem_rdata;
            cur_addr  = mem_exp_addr;
            cur_we    = mem_exp_we;
            cur_wdata = mem_exp_wdata;
         end
         mem_cycles++;
         chk("dmem_addr", mem.dmem_addr, cur_addr);
         chk("dmem_we", mem.dmem_we, cur_we);
         if (cur_we) chk("dmem_wdata", mem.dmem_wdata, cur_wdata);
         chk("in_ready_in_mem", bus.in_ready, 1'b0);
         if (mem_cycles >= cur_lat) begin
            mem.dmem_ready = 1'b1;
            mem.dmem_rdata = cur_rdata;
         end else begin
            mem.dmem_ready = 1'b0;
            mem.dmem_rdata = $urandom;
         end
      end else begin
         if (mem_cycles != 0 && !abort_exp) chk("dmem_req_len", mem_cycles, cur_lat);
         mem_cycles     = 0;
         mem.dmem_ready = 1'($urandom_range(0, 1));
         mem.dmem_rdata = $urandom;
      end
   end

   // WB monitor / scoreboard
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!reset) begin
         if (state_dbg == 2'd2) begin
            if (exp_q.size() == 0) begin
               chk("wb_unexpected", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("wb_rd_we", wb_rd_write_en, e[102]);
               if (e[102]) begin
                  chk("wb_rd_num", wb_rd_num, e[101:98]);
                  chk("wb_rd_in", wb_rd_in, e[97:66]);
               end
               chk("wb_cpsr_we", wb_cpsr_write_en, e[65]);
               if (e[65]) chk("wb_cpsr_in", wb_cpsr_in, e[64:33]);
               chk("redirect_valid", redirect_valid, e[32]);
               if (e[32]) chk("redirect_pc_rel", redirect_pc_rel, e[31:0]);
            end
            chk("retired_in_wb", retired_count, exp_ret);
            exp_ret = exp_ret + 32'd1;
         end else begin
            chk("strobe_outside_wb", {wb_rd_write_en, wb_cpsr_write_en, redirect_valid}, 3'b000);
         end
      end
   end

   // Driver: present bundle, hold until accepted, push expected effect.
   task automatic drive(input vec_t v, output int stalls);
      @(negedge clk);
      bus.in_valid              = 1'b1;
      bus.result                = v.result;
      bus.cpsr_passthrough      = v.cpsr;
      bus.taken                 = v.taken;
      bus.pc_rel                = v.pc_rel;
      bus.rd_num_passthrough    = v.rd;
      bus.rd_val_passthrough    = v.rd_val;
      bus.mem_passthrough       = v.mem;
      bus.is_alu_op_passthrough = v.alu;
      bus.is_cmp_op_passthrough = v.cmp;
      bus.is_ld_op_passthrough  = v.ld;
      bus.is_str_op_passthrough = v.str;
      stalls = 0;
      while (!bus.in_ready && stalls < 300) begin
         @(negedge clk);
         stalls++;
      end
      if (!bus.in_ready) chk("accept_timeout", 1'b0, 1'b1);
      mem_lat       = v.lat;
      mem_rdata     = v.rdata;
      mem_exp_addr  = v.e_addr;
      mem_exp_we    = v.str;
      mem_exp_wdata = v.rd_val;
      mem_exp_valid = v.ld | v.str;
      exp_q.push_back({v.e_rd_we, v.e_rd_num, v.e_rd_in, v.e_cpsr_we, v.e_cpsr, v.e_redir, v.e_pc});
      @(posedge clk);
   endtask

   task automatic go_idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.result   = $urandom;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t v;
      int   st;
      checks = 0;
      errors = 0;
      exp_ret = '0;
      mem_lat = 1; mem_rdata = '0; mem_exp_addr = '0; mem_exp_we = 1'b0;
      mem_exp_wdata = '0; mem_exp_valid = 1'b0; abort_exp = 1'b0; mem_cycles = 0;
      cur_lat = 1; cur_rdata = '0; cur_addr = '0; cur_we = 1'b0; cur_wdata = '0;
      bus.in_valid = 1'b0; bus.result = '0; bus.cpsr_passthrough = '0; bus.taken = 1'b0;
      bus.pc_rel = '0; bus.rd_num_passthrough = '0; bus.rd_val_passthrough = '0;
      bus.mem_passthrough = '0; bus.is_alu_op_passthrough = 1'b0;
      bus.is_cmp_op_passthrough = 1'b0; bus.is_ld_op_passthrough = 1'b0;
      bus.is_str_op_passthrough = 1'b0;
      mem.dmem_ready = 1'b0; mem.dmem_rdata = '0;

      // alu cmp ld str taken | result cpsr pc_rel rd_val mem | rd | lat rdata |
      // e_rd_we e_rd_num e_rd_in | e_cpsr_we e_cpsr | e_redir e_pc | e_addr
      tbl[0] = '{1,0,0,0,0, 7, 0, 0, 0, 0, 6, 0, 0, 1, 6, 7, 0, 0, 0, 0, 0};
      tbl[1] = '{0,0,1,0,0, 0, 0, 0, 0, 9, 8, 3, 32'hDEADBEEF, 1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 9};
      tbl[2] = '{0,0,0,1,0, 0, 0, 0, 32'h55, 11, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11};
      tbl[3] = '{0,1,0,0,0, 0, 32'h40000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40000000, 0, 0, 0};
      tbl[4] = '{0,0,0,0,1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0};
      tbl[5] = '{0,0,0,0,0, 32'hAAAA, 32'h1234, 32'h77, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[6] = '{1,1,0,0,1, 32'h11, 32'h80000000, 32'hFFFFFFF0, 0, 0, 12, 0, 0,
                 1, 12, 32'h11, 1, 32'h80000000, 1, 32'hFFFFFFF0, 0};
      tbl[7] = '{0,0,1,0,0, 0, 0, 0, 0, 32'hFFC00005, 3, 2, 32'h12345678,
                 1, 3, 32'h12345678, 0, 0, 0, 0, 22'h000005};
      tbl[8] = '{0,0,0,1,0, 0, 0, 0, 32'hCAFEF00D, 32'h80300ABC, 1, 4, 0,
                 0, 0, 0, 0, 0, 0, 0, 22'h300ABC};
      tbl[9] = '{1,0,0,0,0, 32'hFFFFFFFF, 0, 0, 0, 0, 15, 0, 0, 1, 15, 32'hFFFFFFFF, 0, 0, 0, 0, 0};

      // Reset values
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dmem_req", mem.dmem_req, 1'b0);
      chk("rst_dmem_addr", mem.dmem_addr, 22'h0);
      chk("rst_strobes", {wb_rd_write_en, wb_cpsr_write_en, redirect_valid, mem.dmem_we}, 4'h0);
      chk("rst_wb_data", {wb_rd_in, wb_cpsr_in, redirect_pc_rel}, 96'h0);
      chk("rst_retired", retired_count, 32'h0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      reset = 1'b0;

      // Table, driven back to back
      for (int i = 0; i < 10; i++) drive(tbl[i], st);
      go_idle();
      drain();
      chk("retired_after_table", retired_count, 32'd10);

      // CMP then taken JMP: second bundle accepted with no stall
      drive(tbl[3], st);
      drive(tbl[4], st);
      chk("b2b_stall", st, 0);
      go_idle();
      drain();

      // Reset in the middle of an LD that memory never answers
      v = tbl[1];
      v.lat = 1000;
      drive(v, st);
      go_idle();
      @(negedge clk);
      chk("abort_req_before", mem.dmem_req, 1'b1);
      #2;
      abort_exp = 1'b1;
      reset = 1'b1;
      #1;
      chk("abort_req_drop", mem.dmem_req, 1'b0);
      chk("abort_no_write", wb_rd_write_en, 1'b0);
      chk("abort_retired", retired_count, 32'h0);
      exp_q.delete();
      exp_ret = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      abort_exp = 1'b0;
      v = tbl[0];
      v.rd = 2; v.result = 32'h1234; v.e_rd_num = 2; v.e_rd_in = 32'h1234;
      drive(v, st);
      go_idle();
      drain();
      chk("after_abort_retired", retired_count, 32'd1);

      // Counter wrap
      @(negedge clk);
      force dut.retired_q = 32'hFFFFFFFF;
      #1;
      release dut.retired_q;
      exp_ret = 32'hFFFFFFFF;
      drive(tbl[5], st);
      go_idle();
      drain();
      chk("retired_wrap", retired_count, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
